// File: rtl/fitness_pkg.sv
// fitness_pkg: shared sizes and FSM encoding for the fitness evaluator.
package fitness_pkg;
  localparam int NUM_IND   = 15;
  localparam int GENE_BITS = 125;
  localparam int CHUNK     = 25;
  localparam int SCORE_W   = $clog2(GENE_BITS + 1);
  localparam int IDX_W     = 4;
  localparam int CHUNKS    = GENE_BITS / CHUNK;
  localparam int CNT_W     = $clog2(CHUNKS);
  localparam int POP_W     = NUM_IND * GENE_BITS;
  localparam int POS_W     = $clog2(POP_W);
  localparam int TPOS_W    = $clog2(GENE_BITS);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, EVAL = 2'd2, DONE = 2'd3} state_e;
endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: combinational count of set bits in one CHUNK-bit slice.
module popcount_chunk import fitness_pkg::*; (
  input  logic [CHUNK-1:0]   bits_i,
  output logic [SCORE_W-1:0] count_o
);
  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHUNK; i++) count_o = count_o + SCORE_W'(bits_i[i]);
  end
endmodule

// File: rtl/fitness_eval.sv
// fitness_eval: scores a snapshotted population against a target, one chunk per clock.
// Optional runner-up tracking is enabled with FITNESS_ELITE2_EN.
module fitness_eval import fitness_pkg::*; (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [POP_W-1:0]           population,
  input  logic [GENE_BITS-1:0]       target,
  output logic [NUM_IND*SCORE_W-1:0] scores,
  output logic [IDX_W-1:0]           best_idx,
  output logic [SCORE_W-1:0]         best_score,
`ifdef FITNESS_ELITE2_EN
  output logic [IDX_W-1:0]           second_idx,
  output logic [SCORE_W-1:0]         second_score,
`endif
  output logic                       busy,
  output logic                       done
);
  state_e state_q, state_d;
  logic [POP_W-1:0]     pop_q;
  logic [GENE_BITS-1:0] tgt_q;
  logic [IDX_W-1:0]     ind_cnt_q, wr_idx_q, best_idx_q;
  logic [CNT_W-1:0]     chunk_cnt_q;
  logic [SCORE_W-1:0]   acc_q, best_score_q, pc, sum;
  logic [SCORE_W-1:0]   sc_q [NUM_IND];
  logic [CHUNK-1:0]     match_q;
  logic                 mvld_q, mlast_q;
  logic                 issue, last_chunk, completing, last_ind;
  logic [POS_W-1:0]     pos;
  logic [TPOS_W-1:0]    tpos;
`ifdef FITNESS_ELITE2_EN
  logic [IDX_W-1:0]     second_idx_q;
  logic [SCORE_W-1:0]   second_score_q;
  assign second_idx   = second_idx_q;
  assign second_score = second_score_q;
`endif
  // Chunk selection is registered ahead of the popcount so the wide snapshot mux
  // and the adder tree sit in separate cycles.
  assign issue      = ind_cnt_q != IDX_W'(NUM_IND);
  assign last_chunk = chunk_cnt_q == CNT_W'(CHUNKS - 1);
  assign pos        = POS_W'(ind_cnt_q) * POS_W'(GENE_BITS) + POS_W'(chunk_cnt_q) * POS_W'(CHUNK);
  assign tpos       = TPOS_W'(chunk_cnt_q) * TPOS_W'(CHUNK);
  assign sum        = acc_q + pc;
  assign completing = state_q == EVAL && mvld_q && mlast_q;
  assign last_ind   = wr_idx_q == IDX_W'(NUM_IND - 1);
  popcount_chunk u_pc (.bits_i(match_q), .count_o(pc));
  always_comb begin
    state_d = state_q == IDLE ? (start ? LOAD : IDLE) :
              state_q == LOAD ? EVAL :
              state_q == EVAL ? ((completing && last_ind) ? DONE : EVAL) : IDLE;
    busy    = state_q == LOAD || state_q == EVAL;
    done    = state_q == DONE;
  end
  for (genvar g = 0; g < NUM_IND; g++) begin : g_sc
    assign scores[g*SCORE_W +: SCORE_W] = sc_q[g];
  end
  assign best_idx   = best_idx_q;
  assign best_score = best_score_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pop_q        <= '0;
      tgt_q        <= '0;
      ind_cnt_q    <= '0;
      wr_idx_q     <= '0;
      chunk_cnt_q  <= '0;
      acc_q        <= '0;
      match_q      <= '0;
      mvld_q       <= 1'b0;
      mlast_q      <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      sc_q         <= '{default: '0};
`ifdef FITNESS_ELITE2_EN
      second_idx_q   <= '0;
      second_score_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == LOAD) begin
        pop_q        <= population;
        tgt_q        <= target;
        ind_cnt_q    <= '0;
        wr_idx_q     <= '0;
        chunk_cnt_q  <= '0;
        acc_q        <= '0;
        mvld_q       <= 1'b0;
        mlast_q      <= 1'b0;
        best_idx_q   <= '0;
        best_score_q <= '0;
        sc_q         <= '{default: '0};
`ifdef FITNESS_ELITE2_EN
        second_idx_q   <= '0;
        second_score_q <= '0;
`endif
      end else if (state_q == EVAL) begin
        mvld_q  <= issue;
        mlast_q <= last_chunk;
        match_q <= ~(pop_q[pos +: CHUNK] ^ tgt_q[tpos +: CHUNK]);
        if (issue) begin
          chunk_cnt_q <= last_chunk ? '0 : chunk_cnt_q + 1'b1;
          if (last_chunk) ind_cnt_q <= ind_cnt_q + 1'b1;
        end
        if (mvld_q) begin
          acc_q <= mlast_q ? '0 : sum;
          if (mlast_q) begin
            sc_q[wr_idx_q] <= sum;
            wr_idx_q       <= wr_idx_q + 1'b1;
            // Strict compare: equal scores never displace an earlier index.
            if (sum > best_score_q) begin
              best_score_q <= sum;
              best_idx_q   <= wr_idx_q;
`ifdef FITNESS_ELITE2_EN
              second_score_q <= best_score_q;
              second_idx_q   <= best_idx_q;
`endif
            end
`ifdef FITNESS_ELITE2_EN
            else if (sum > second_score_q) begin
              second_score_q <= sum;
              second_idx_q   <= wr_idx_q;
            end
`endif
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fitness_eval.sv
// tb_fitness_eval: directed table plus randomized runs against a popcount reference model.
module tb_fitness_eval;
  import fitness_pkg::*;
  localparam int LAT = 1 + NUM_IND * GENE_BITS / CHUNK + 1;
  typedef struct {
    string                      name;
    logic [POP_W-1:0]           pop;
    logic [GENE_BITS-1:0]       tgt;
    logic [NUM_IND*SCORE_W-1:0] esc;
    int                         ebi, ebs, esi, ess;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [POP_W-1:0]           population = '0;
  logic [GENE_BITS-1:0]       target = '0;
  logic [NUM_IND*SCORE_W-1:0] scores;
  logic [IDX_W-1:0]           best_idx;
  logic [SCORE_W-1:0]         best_score;
  logic                       busy, done;
`ifdef FITNESS_ELITE2_EN
  logic [IDX_W-1:0]           second_idx;
  logic [SCORE_W-1:0]         second_score;
`endif
  int vec_cnt = 0, err_cnt = 0;
  vec_t tbl [3];
  fitness_eval dut (
    .clk(clk), .rst_n(rst_n), .start(start), .population(population), .target(target),
    .scores(scores), .best_idx(best_idx), .best_score(best_score),
`ifdef FITNESS_ELITE2_EN
    .second_idx(second_idx), .second_score(second_score),
`endif
    .busy(busy), .done(done));
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic [GENE_BITS-1:0] rnd_gene();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[GENE_BITS-1:0];
  endfunction
  function automatic logic [GENE_BITS-1:0] with_matches(input logic [GENE_BITS-1:0] t, input int n);
    logic [GENE_BITS-1:0] ones;
    ones = '1;
    return t ^ (ones >> n);
  endfunction
  task automatic model(input logic [POP_W-1:0] p, input logic [GENE_BITS-1:0] t,
                       output logic [NUM_IND*SCORE_W-1:0] esc, output int ebi, ebs, esi, ess);
    int s [NUM_IND];
    ebi = 0; ebs = 0; esi = 0; ess = 0;
    for (int i = 0; i < NUM_IND; i++) begin
      s[i] = GENE_BITS - $countones(p[i*GENE_BITS +: GENE_BITS] ^ t);
      esc[i*SCORE_W +: SCORE_W] = SCORE_W'(s[i]);
      if (s[i] > ebs) begin ebs = s[i]; ebi = i; end
    end
    for (int i = 0; i < NUM_IND; i++)
      if (i != ebi && s[i] > ess) begin ess = s[i]; esi = i; end
  endtask
  task automatic launch(input logic [POP_W-1:0] p, input logic [GENE_BITS-1:0] t, output int lat);
    population = p; target = t; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1 lat++; end
  endtask
  task automatic check_results(input string tag, input logic [NUM_IND*SCORE_W-1:0] esc,
                               input int ebi, ebs, esi, ess);
    check({tag, " done"}, 32'(done), 1);
    check({tag, " busy"}, 32'(busy), 0);
    for (int i = 0; i < NUM_IND; i++)
      check($sformatf("%s score%0d", tag, i), 32'(scores[i*SCORE_W +: SCORE_W]), 32'(esc[i*SCORE_W +: SCORE_W]));
    check({tag, " best_idx"}, 32'(best_idx), ebi);
    check({tag, " best_score"}, 32'(best_score), ebs);
`ifdef FITNESS_ELITE2_EN
    check({tag, " second_idx"}, 32'(second_idx), esi);
    check({tag, " second_score"}, 32'(second_score), ess);
`endif
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(done), 0);
  endtask
  initial begin
    logic [POP_W-1:0]           p;
    logic [GENE_BITS-1:0]       t;
    logic [NUM_IND*SCORE_W-1:0] esc;
    int ebi, ebs, esi, ess, lat, extra;
    #12;
    check("rst busy", 32'(busy), 0);
    check("rst done", 32'(done), 0);
    check("rst scores", 32'(|scores), 0);
    check("rst best", 32'({best_idx, best_score}), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tbl[0].name = "allzero"; tbl[0].pop = '0; tbl[0].tgt = '0;
    for (int i = 0; i < NUM_IND; i++) tbl[0].esc[i*SCORE_W +: SCORE_W] = 7'd125;
    tbl[0].ebi = 0; tbl[0].ebs = 125; tbl[0].esi = 1; tbl[0].ess = 125;
    t = rnd_gene();
    tbl[1].name = "ind7"; tbl[1].tgt = t;
    for (int i = 0; i < NUM_IND; i++) begin
      tbl[1].pop[i*GENE_BITS +: GENE_BITS] = (i == 7) ? t : ~t;
      tbl[1].esc[i*SCORE_W +: SCORE_W] = (i == 7) ? 7'd125 : 7'd0;
    end
    tbl[1].ebi = 7; tbl[1].ebs = 125; tbl[1].esi = 0; tbl[1].ess = 0;
    t = rnd_gene();
    tbl[2].name = "ramp"; tbl[2].tgt = t;
    for (int i = 0; i < NUM_IND; i++) begin
      tbl[2].pop[i*GENE_BITS +: GENE_BITS] = with_matches(t, i < 13 ? 10 * i : 0);
      tbl[2].esc[i*SCORE_W +: SCORE_W] = SCORE_W'(i < 13 ? 10 * i : 0);
    end
    tbl[2].ebi = 12; tbl[2].ebs = 120; tbl[2].esi = 11; tbl[2].ess = 110;
    for (int k = 0; k < 3; k++) begin
      launch(tbl[k].pop, tbl[k].tgt, lat);
      check({tbl[k].name, " latency"}, lat, LAT);
      check_results(tbl[k].name, tbl[k].esc, tbl[k].ebi, tbl[k].ebs, tbl[k].esi, tbl[k].ess);
    end
    // 50,90,90,70 then zeros: tie on 90 must keep index 1 as best
    t = rnd_gene();
    for (int i = 0; i < NUM_IND; i++)
      p[i*GENE_BITS +: GENE_BITS] = with_matches(t, i == 0 ? 50 : (i == 1 || i == 2) ? 90 : i == 3 ? 70 : 0);
    model(p, t, esc, ebi, ebs, esi, ess);
    launch(p, t, lat);
    check("elite latency", lat, LAT);
    check("elite best_idx const", 32'(best_idx), 1);
    check_results("elite", esc, ebi, ebs, esi, ess);
    for (int r = 0; r < 6; r++) begin
      t = rnd_gene();
      for (int i = 0; i < NUM_IND; i++)
        p[i*GENE_BITS +: GENE_BITS] = r[0] ? with_matches(t, $urandom_range(60, 64)) : rnd_gene();
      model(p, t, esc, ebi, ebs, esi, ess);
      launch(p, t, lat);
      check($sformatf("rand%0d latency", r), lat, LAT);
      check_results($sformatf("rand%0d", r), esc, ebi, ebs, esi, ess);
    end
    t = rnd_gene();
    for (int i = 0; i < NUM_IND; i++) p[i*GENE_BITS +: GENE_BITS] = rnd_gene();
    model(p, t, esc, ebi, ebs, esi, ess);
    population = p; target = t; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (lat == 1) begin population = ~p; target = ~t; end
      start = (lat == 5 || lat == 40);
      @(posedge clk); #1 lat++;
    end
    start = 1'b0;
    check("snap latency", lat, LAT);
    check_results("snap", esc, ebi, ebs, esi, ess);
    extra = 0;
    repeat (100) begin @(posedge clk); #1 if (done) extra++; end
    check("snap no queued run", extra, 0);
    t = rnd_gene();
    for (int i = 0; i < NUM_IND; i++) p[i*GENE_BITS +: GENE_BITS] = rnd_gene();
    population = p; target = t; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    while (lat < 30) begin @(posedge clk); #1 lat++; end
    check("rstmid busy before", 32'(busy), 1);
    check("rstmid scores before", 32'(|scores), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid busy", 32'(busy), 0);
    check("rstmid done", 32'(done), 0);
    check("rstmid scores", 32'(|scores), 0);
    check("rstmid best", 32'({best_idx, best_score}), 0);
    @(posedge clk); #1;
    check("rstmid held", 32'(busy), 0);
    rst_n = 1'b1;
    t = rnd_gene();
    for (int i = 0; i < NUM_IND; i++) p[i*GENE_BITS +: GENE_BITS] = with_matches(t, $urandom_range(0, 125));
    model(p, t, esc, ebi, ebs, esi, ess);
    launch(p, t, lat);
    check("after rst latency", lat, LAT);
    check_results("after rst", esc, ebi, ebs, esi, ess);
    t = rnd_gene();
    for (int i = 0; i < NUM_IND; i++) p[i*GENE_BITS +: GENE_BITS] = rnd_gene();
    model(p, t, esc, ebi, ebs, esi, ess);
    population = p; target = t; start = 1'b1;
    @(posedge clk); #1 lat = 0;
    while (done !== 1'b1 && lat < 200) begin @(posedge clk); #1 lat++; end
    check("hold latency", lat, LAT);
    check_results("hold1", esc, ebi, ebs, esi, ess);
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin @(posedge clk); #1 lat++; end
    start = 1'b0;
    check("hold gap", lat, LAT + 2);
    check_results("hold2", esc, ebi, ebs, esi, ess);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
